gauss_filter_ctrl: RTL and testbench

GAUSS_FILTER_CTRL -- requirements
Module: gauss_filter_ctrl

---
 rtl/gauss_filter_ctrl.sv | 140 ++++++++++++++
 tb/tb_gauss_filter_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_filter_ctrl.sv
// rtl/gauss_filter_ctrl.sv - Gaussian filter tap loader and bit upsampler with post-packet flush
module gauss_filter_ctrl #(
   parameter int SAMPLE_PER_SYMBOL = 8,
   parameter int FLUSH_SAMPLES = 8,
   parameter int GAUSS_FILTER_BIT_WIDTH = 6,
   parameter logic [9*GAUSS_FILTER_BIT_WIDTH-1:0] TAP_TABLE =
      {6'd4, 6'd4, 6'd3, 6'd2, 6'd1, 6'd1, 6'd0, 6'd0, 6'd0}
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     cfg_reload,
   output logic                                     cfg_busy,
   input  logic                                     bit_in,
   input  logic                                     bit_in_valid,
   input  logic                                     bit_in_last,
   output logic                                     bit_in_ready,
   output logic [3:0]                               tap_index,
   output logic signed [GAUSS_FILTER_BIT_WIDTH-1:0] tap_value,
   output logic                                     bit_upsample,
   output logic                                     bit_upsample_valid,
   output logic                                     bit_upsample_valid_last
);

   typedef enum logic [1:0] {LOAD, IDLE, STREAM, FLUSH} state_t;

   localparam logic [4:0] SPS_LAST = 5'(SAMPLE_PER_SYMBOL - 1);
   localparam logic [4:0] FL_LAST  = 5'(FLUSH_SAMPLES - 1);

   state_t     state, state_n;
   logic       armed;
   logic [3:0] load_idx, load_idx_n;
   logic [4:0] cnt, cnt_n;
   logic       pkt_active, pkt_active_n;
   logic       cur_last, cur_last_n;
   logic       up_bit_n, up_valid_n, up_last_n;
   logic       accept;
   logic [GAUSS_FILTER_BIT_WIDTH-1:0] taps [0:8];

   for (genvar g = 0; g < 9; g++) begin : g_tap
      assign taps[g] = TAP_TABLE[g*GAUSS_FILTER_BIT_WIDTH +: GAUSS_FILTER_BIT_WIDTH];
   end

   // armed holds everything quiet for the cycle after reset so LOAD k=0 lands right after release
   always_comb begin
      state_n      = state;
      load_idx_n   = load_idx;
      cnt_n        = cnt;
      pkt_active_n = pkt_active;
      cur_last_n   = cur_last;
      up_bit_n     = bit_upsample;
      up_valid_n   = 1'b0;
      up_last_n    = 1'b0;
      bit_in_ready = 1'b0;
      cfg_busy     = 1'b0;
      tap_index    = 4'hF;
      tap_value    = '0;
      if (armed) begin
         case (state)
            LOAD: begin
               cfg_busy  = 1'b1;
               tap_index = load_idx;
               tap_value = taps[load_idx];
               if (load_idx == 4'd8) begin
                  state_n    = IDLE;
                  load_idx_n = '0;
               end else begin
                  load_idx_n = load_idx + 4'd1;
               end
            end
            IDLE: begin
               bit_in_ready = pkt_active | ~cfg_reload;
               if (!pkt_active && cfg_reload) begin
                  state_n    = LOAD;
                  load_idx_n = '0;
               end
            end
            STREAM: begin
               if (cnt != SPS_LAST) begin
                  cnt_n      = cnt + 5'd1;
                  up_valid_n = 1'b1;
               end else if (cur_last) begin
                  state_n    = FLUSH;
                  cnt_n      = '0;
                  up_valid_n = 1'b1;
                  up_last_n  = (FL_LAST == 5'd0);
               end else begin
                  bit_in_ready = 1'b1;
                  state_n      = IDLE;
               end
            end
            FLUSH: begin
               if (cnt != FL_LAST) begin
                  cnt_n      = cnt + 5'd1;
                  up_valid_n = 1'b1;
                  up_last_n  = (cnt + 5'd1 == FL_LAST);
               end else begin
                  state_n      = IDLE;
                  pkt_active_n = 1'b0;
               end
            end
            default: state_n = IDLE;
         endcase
      end
      accept = bit_in_valid & bit_in_ready;
      if (accept) begin
         state_n      = STREAM;
         cnt_n        = '0;
         cur_last_n   = bit_in_last;
         pkt_active_n = 1'b1;
         up_bit_n     = bit_in;
         up_valid_n   = 1'b1;
         up_last_n    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state                   <= LOAD;
         armed                   <= 1'b0;
         load_idx                <= '0;
         cnt                     <= '0;
         pkt_active              <= 1'b0;
         cur_last                <= 1'b0;
         bit_upsample            <= 1'b0;
         bit_upsample_valid      <= 1'b0;
         bit_upsample_valid_last <= 1'b0;
      end else begin
         state                   <= state_n;
         armed                   <= 1'b1;
         load_idx                <= load_idx_n;
         cnt                     <= cnt_n;
         pkt_active              <= pkt_active_n;
         cur_last                <= cur_last_n;
         bit_upsample            <= up_bit_n;
         bit_upsample_valid      <= up_valid_n;
         bit_upsample_valid_last <= up_last_n;
      end
   end

endmodule

// File: tb/tb_gauss_filter_ctrl.sv
// tb/tb_gauss_filter_ctrl.sv - self-checking bench for gauss_filter_ctrl
`timescale 1ns/1ps
module tb_gauss_filter_ctrl;
   localparam int SPS = 8;
   localparam int FL  = 8;
   localparam int W   = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, cfg_reload, bit_in, bit_in_valid, bit_in_last;
   logic cfg_busy, bit_in_ready, bit_upsample, bit_upsample_valid, bit_upsample_valid_last;
   logic [3:0] tap_index;
   logic signed [W-1:0] tap_value;

   logic rst_b, cfg_reload_b, bit_in_b, bit_in_valid_b, bit_in_last_b;
   logic cfg_busy_b, bit_in_ready_b, up_b, up_valid_b, up_last_b;
   logic [3:0] tap_index_b;
   logic signed [W-1:0] tap_value_b;

   gauss_filter_ctrl dut (
      .clk(clk), .rst(rst), .cfg_reload(cfg_reload), .cfg_busy(cfg_busy),
      .bit_in(bit_in), .bit_in_valid(bit_in_valid), .bit_in_last(bit_in_last),
      .bit_in_ready(bit_in_ready), .tap_index(tap_index), .tap_value(tap_value),
      .bit_upsample(bit_upsample), .bit_upsample_valid(bit_upsample_valid),
      .bit_upsample_valid_last(bit_upsample_valid_last)
   );

   gauss_filter_ctrl #(.SAMPLE_PER_SYMBOL(4), .FLUSH_SAMPLES(2)) dut_b (
      .clk(clk), .rst(rst_b), .cfg_reload(cfg_reload_b), .cfg_busy(cfg_busy_b),
      .bit_in(bit_in_b), .bit_in_valid(bit_in_valid_b), .bit_in_last(bit_in_last_b),
      .bit_in_ready(bit_in_ready_b), .tap_index(tap_index_b), .tap_value(tap_value_b),
      .bit_upsample(up_b), .bit_upsample_valid(up_valid_b),
      .bit_upsample_valid_last(up_last_b)
   );

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: expected sample stream as a queue of {last, bit}
   int         taps_exp [9] = '{0, 0, 0, 1, 1, 2, 3, 4, 4};
   bit         model_on = 1'b0;
   bit         m_armed = 1'b0;
   int         m_load = 0;
   bit         m_pkt = 1'b0;
   bit         m_last_queued = 1'b0;
   logic       m_hold = 1'b0;
   logic [1:0] m_q [$];
   int         acc_count = 0;

   logic [1:0] cap [$];
   int         cyc = 0, first_v = -1, last_v = -1, busy_cnt = 0;

   always @(negedge clk) begin
      if (model_on) begin
         logic e_ready, e_busy, e_v, e_b, e_l;
         int   e_idx, e_val;
         bit   q_empty;
         q_empty = (m_q.size() == 0);
         e_busy = 1'b0; e_idx = 15; e_val = 0; e_ready = 1'b0;
         e_v = 1'b0; e_b = m_hold; e_l = 1'b0;
         if (m_armed && m_load >= 0) begin
            e_busy = 1'b1;
            e_idx  = m_load;
            e_val  = taps_exp[m_load];
         end else if (m_armed) begin
            if (q_empty) e_ready = m_pkt || !cfg_reload;
            else         e_ready = (m_q.size() == 1) && !m_last_queued;
            if (!q_empty) begin
               e_v = 1'b1;
               e_b = m_q[0][0];
               e_l = m_q[0][1];
            end
         end
         check("cfg_busy", int'(cfg_busy), int'(e_busy));
         check("tap_index", int'(tap_index), e_idx);
         check("tap_value", int'(tap_value), e_val);
         check("bit_in_ready", int'(bit_in_ready), int'(e_ready));
         check("up_valid", int'(bit_upsample_valid), int'(e_v));
         check("up_bit", int'(bit_upsample), int'(e_b));
         check("up_last", int'(bit_upsample_valid_last), int'(e_l));

         cyc++;
         if (bit_upsample_valid) begin
            cap.push_back({bit_upsample_valid_last, bit_upsample});
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
         end
         if (cfg_busy) busy_cnt++;

         if (!rst) begin
            m_armed = 1'b0; m_load = 0; m_pkt = 1'b0; m_last_queued = 1'b0;
            m_hold = 1'b0; m_q.delete();
         end else if (!m_armed) begin
            m_armed = 1'b1;
         end else if (m_load >= 0) begin
            m_load++;
            if (m_load == 9) m_load = -1;
         end else begin
            if (q_empty && !m_pkt && cfg_reload) m_load = 0;
            if (!q_empty) begin
               m_hold = m_q[0][0];
               if (m_q[0][1]) begin
                  m_pkt = 1'b0;
                  m_last_queued = 1'b0;
               end
               void'(m_q.pop_front());
            end
            if (bit_in_valid && e_ready) begin
               acc_count++;
               m_pkt = 1'b1;
               for (int i = 0; i < SPS; i++) m_q.push_back({1'b0, bit_in});
               if (bit_in_last) begin
                  m_last_queued = 1'b1;
                  for (int i = 0; i < FL; i++) m_q.push_back({i == FL - 1, bit_in});
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic clear_cap();
      cap.delete();
      first_v = -1;
      last_v = -1;
      busy_cnt = 0;
   endtask

   task automatic send_bit(input logic b, input logic l);
      int a0;
      a0 = acc_count;
      bit_in = b; bit_in_last = l; bit_in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (acc_count != a0) return;
      end
      check("accept_timeout", 0, 1);
   endtask

   task automatic pack(input int n, output logic [31:0] vb, output logic [31:0] vl);
      vb = '0; vl = '0;
      for (int i = 0; i < n && i < cap.size(); i++) begin
         vb[i] = cap[i][0];
         vl[i] = cap[i][1];
      end
   endtask

   initial begin
      logic [31:0] vb, vl;
      int j, a0;
      rst = 1'b0; cfg_reload = 1'b0; bit_in = 1'b0; bit_in_valid = 1'b0; bit_in_last = 1'b0;
      @(posedge clk); #1;
      model_on = 1'b1;
      @(posedge clk); #1;
      clear_cap();
      rst = 1'b1;
      idle(14);
      check("load_busy_cycles", busy_cnt, 9);

      // three-bit packet back to back
      clear_cap();
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b1);
      bit_in_valid = 1'b0;
      idle(40);
      pack(32, vb, vl);
      check("pkt3_count", cap.size(), 32);
      check("pkt3_bits", int'(vb), 32'hFFFF00FF);
      check("pkt3_last", int'(vl), 32'h80000000);
      check("pkt3_span", last_v - first_v + 1, 32);

      // underrun gap of 5 cycles, reload pulse ignored mid-packet
      clear_cap();
      send_bit(1'b1, 1'b0);
      bit_in_valid = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         cfg_reload = (i == 10);
      end
      cfg_reload = 1'b0;
      send_bit(1'b0, 1'b1);
      bit_in_valid = 1'b0;
      idle(30);
      pack(24, vb, vl);
      check("gap_count", cap.size(), 24);
      check("gap_span", last_v - first_v + 1, 29);
      check("gap_bits", int'(vb), 32'h000000FF);
      check("gap_last", int'(vl), 32'h00800000);
      check("gap_busy", busy_cnt, 0);

      // reload beats a simultaneous bit
      clear_cap();
      a0 = acc_count;
      cfg_reload = 1'b1; bit_in_valid = 1'b1; bit_in = 1'b1; bit_in_last = 1'b1;
      @(negedge clk);
      check("reload_ready", int'(bit_in_ready), 0);
      j = 0;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk); #1;
         cfg_reload = 1'b0;
         if (acc_count != a0) begin
            j = i;
            break;
         end
      end
      bit_in_valid = 1'b0;
      check("reload_accept_cycle", j, 11);
      check("reload_busy", busy_cnt, 9);
      idle(25);

      // reset during sample 10
      clear_cap();
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 20 && cap.size() < 9; i++) begin
         @(posedge clk); #1;
      end
      rst = 1'b0; bit_in_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_valid", int'(bit_upsample_valid), 0);
      check("rst_bit", int'(bit_upsample), 0);
      check("rst_tap", int'(tap_index), 15);
      check("rst_busy", int'(cfg_busy), 0);
      check("rst_ready", int'(bit_in_ready), 0);
      @(posedge clk); #1;
      clear_cap();
      rst = 1'b1;
      idle(14);
      check("rst_reload_busy", busy_cnt, 9);
      check("rst_no_output", cap.size(), 0);

      // randomized packets with gaps, junk and reload pulses
      for (int p = 0; p < 20; p++) begin
         int len;
         len = $urandom_range(1, 5);
         for (int k = 0; k < len; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
               bit_in_valid = 1'b0;
               bit_in = 1'($urandom);
               bit_in_last = 1'($urandom);
               cfg_reload = ($urandom_range(0, 3) == 0);
               @(posedge clk); #1;
            end
            cfg_reload = 1'b0;
            send_bit(1'($urandom), k == len - 1);
         end
      end
      bit_in_valid = 1'b0;
      idle(40);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Short-symbol instance: single-bit packet of 0
   initial begin
      int bc, nv, nones, nl, lpos, fc, lc;
      rst_b = 1'b0; cfg_reload_b = 1'b0; bit_in_b = 1'b0; bit_in_valid_b = 1'b0; bit_in_last_b = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_b = 1'b1;
      bc = 0;
      repeat (12) begin
         @(negedge clk);
         if (cfg_busy_b) bc++;
      end
      check("b_load_cycles", bc, 9);
      @(posedge clk); #1;
      bit_in_valid_b = 1'b1; bit_in_b = 1'b0; bit_in_last_b = 1'b1;
      @(negedge clk);
      check("b_ready", int'(bit_in_ready_b), 1);
      @(posedge clk); #1;
      bit_in_valid_b = 1'b0; bit_in_b = 1'b1;
      nv = 0; nones = 0; nl = 0; lpos = 0; fc = -1; lc = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (up_valid_b) begin
            nv++;
            if (fc < 0) fc = i;
            lc = i;
            if (up_b) nones++;
            if (up_last_b) begin
               nl++;
               lpos = nv;
            end
         end else if (up_last_b) begin
            nl += 100;
         end
      end
      check("b_count", nv, 6);
      check("b_ones", nones, 0);
      check("b_last_pos", lpos, 6);
      check("b_last_count", nl, 1);
      check("b_span", lc - fc + 1, 6);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
